pipe_register: RTL and testbench

PIPE_REGISTER -- requirements
Module: pipe_register

---
 rtl/pipe_pkg.sv | 18 +
 rtl/pipe_reg_slot.sv | 26 ++
 rtl/pipe_register.sv | 118 +++++++++++
 tb/tb_pipe_register.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// pipe_pkg : shared state encoding for the pipe_register skid buffer.
// Revision : 1.0
// ============================================================================
package pipe_pkg;

    // State value doubles as the held-entry count.
    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_FULL  = 2'd1;
    localparam logic [1:0] ST_SKID  = 2'd2;

    function automatic logic state_ready(input logic [1:0] st);
        return (st != ST_SKID);
    endfunction

endpackage : pipe_pkg
`default_nettype wire

// File: rtl/pipe_reg_slot.sv
`default_nettype none
// ============================================================================
// pipe_reg_slot : WIDTH-bit storage register with load enable.
// Revision      : 1.0
// ============================================================================
module pipe_reg_slot #(
    parameter int                 WIDTH       = 32,
    parameter logic [WIDTH-1:0]   RESET_VALUE = '0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load,
    input  logic [WIDTH-1:0]  d,
    output logic [WIDTH-1:0]  q
);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            q <= RESET_VALUE;
        end else if (load) begin
            q <= d;
        end
    end

endmodule : pipe_reg_slot
`default_nettype wire

// File: rtl/pipe_register.sv
`default_nettype none
// ============================================================================
// pipe_register : two-entry skid buffer with registered in_ready and flush.
// Revision      : 1.0
// ============================================================================
module pipe_register
    import pipe_pkg::*;
#(
    parameter int                 WIDTH       = 32,
    parameter logic [WIDTH-1:0]   RESET_VALUE = '0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_data,
    input  logic              flush,
    output logic [1:0]        occupancy
);

    logic [1:0]        state;
    logic [1:0]        state_next;
    logic              accept;
    logic              consume;
    logic              main_load;
    logic              skid_load;
    logic [WIDTH-1:0]  main_d;
    logic [WIDTH-1:0]  skid_d;
    logic [WIDTH-1:0]  skid_q;

    assign accept    = in_valid && in_ready;
    assign consume   = out_valid && out_ready;
    assign out_valid = (state != ST_EMPTY);
    assign occupancy = state;

    always_comb begin
        state_next = state;
        main_load  = 1'b0;
        skid_load  = 1'b0;
        main_d     = in_data;
        skid_d     = in_data;
        if (flush) begin
            state_next = ST_EMPTY;
            main_load  = 1'b1;
            skid_load  = 1'b1;
            main_d     = RESET_VALUE;
            skid_d     = RESET_VALUE;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (accept) begin
                        main_load  = 1'b1;
                        state_next = ST_FULL;
                    end
                end
                ST_FULL: begin
                    if (accept && consume) begin
                        main_load = 1'b1;
                    end else if (accept) begin
                        skid_load  = 1'b1;
                        state_next = ST_SKID;
                    end else if (consume) begin
                        state_next = ST_EMPTY;
                    end
                end
                ST_SKID: begin
                    // in_ready is low here, so only the drain path exists.
                    if (consume) begin
                        main_load  = 1'b1;
                        main_d     = skid_q;
                        state_next = ST_FULL;
                    end
                end
                default: begin
                    state_next = ST_EMPTY;
                end
            endcase
        end
    end

    // in_ready is derived from the next state so it is a pure flop output.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= ST_EMPTY;
            in_ready <= 1'b1;
        end else begin
            state    <= state_next;
            in_ready <= state_ready(state_next);
        end
    end

    pipe_reg_slot #(
        .WIDTH       (WIDTH),
        .RESET_VALUE (RESET_VALUE)
    ) u_main (
        .clock (clock),
        .reset (reset),
        .load  (main_load),
        .d     (main_d),
        .q     (out_data)
    );

    pipe_reg_slot #(
        .WIDTH       (WIDTH),
        .RESET_VALUE (RESET_VALUE)
    ) u_skid (
        .clock (clock),
        .reset (reset),
        .load  (skid_load),
        .d     (skid_d),
        .q     (skid_q)
    );

endmodule : pipe_register
`default_nettype wire

// File: tb/tb_pipe_register.sv
`default_nettype none
// ============================================================================
// tb_pipe_register : directed scenarios plus queue-model scoreboard (8/64 bit).
// Revision         : 1.0
// ============================================================================
module tb_pipe_register;

    localparam logic [7:0] A_RST = 8'hA5;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset;

    logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_flush;
    logic [7:0]  a_in_data, a_out_data;
    logic [1:0]  a_occ;

    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_flush;
    logic [63:0] b_in_data, b_out_data;
    logic [1:0]  b_occ;

    int checks = 0;
    int errors = 0;

    pipe_register #(.WIDTH(8), .RESET_VALUE(A_RST)) dut_a (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (a_in_valid),
        .in_ready  (a_in_ready),
        .in_data   (a_in_data),
        .out_valid (a_out_valid),
        .out_ready (a_out_ready),
        .out_data  (a_out_data),
        .flush     (a_flush),
        .occupancy (a_occ)
    );

    pipe_register #(.WIDTH(64)) dut_b (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .in_data   (b_in_data),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .out_data  (b_out_data),
        .flush     (b_flush),
        .occupancy (b_occ)
    );

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        a_in_valid = 1'b0; a_out_ready = 1'b0; a_flush = 1'b0; a_in_data = '0;
        b_in_valid = 1'b0; b_out_ready = 1'b0; b_flush = 1'b0; b_in_data = '0;
        #12;
        checks++; if (a_occ !== 2'd0) begin errors++; $display("FAIL reset_occ: got %0d want 0", a_occ); end
        checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", a_out_valid); end
        checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", a_in_ready); end
        checks++; if (a_out_data !== A_RST) begin errors++; $display("FAIL reset_out_data: got %h want %h", a_out_data, A_RST); end
        checks++; if (b_out_data !== 64'd0) begin errors++; $display("FAIL reset_out_data64: got %h want 0", b_out_data); end
        @(negedge clock);
        reset = 1'b1;
        tick();
        checks++; if (a_occ !== 2'd0) begin errors++; $display("FAIL reset_idle_occ: got %0d want 0", a_occ); end
    endtask

    task automatic test_streaming;
        logic [7:0] words [3];
        words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33;
        a_out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a_in_valid = 1'b1;
            a_in_data  = words[i];
            tick();
            checks++; if (a_out_data !== words[i]) begin errors++; $display("FAIL stream_data[%0d]: got %h want %h", i, a_out_data, words[i]); end
            checks++; if (a_occ !== 2'd1) begin errors++; $display("FAIL stream_occ[%0d]: got %0d want 1", i, a_occ); end
            checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL stream_in_ready[%0d]: got %b want 1", i, a_in_ready); end
        end
        a_in_valid = 1'b0;
        tick();
        checks++; if (a_occ !== 2'd0) begin errors++; $display("FAIL stream_drain_occ: got %0d want 0", a_occ); end
    endtask

    task automatic test_backpressure;
        logic [7:0] s_data [6];
        logic       s_valid [6];
        logic       s_ready [6];
        logic [1:0] e_occ [6];
        logic       e_rdy [6];
        logic [7:0] e_data [6];
        s_data  = '{8'h0A, 8'h0B, 8'h0C, 8'h0C, 8'h0C, 8'h00};
        s_valid = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        s_ready = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        e_occ   = '{2'd1, 2'd2, 2'd2, 2'd1, 2'd1, 2'd0};
        e_rdy   = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        e_data  = '{8'h0A, 8'h0A, 8'h0A, 8'h0B, 8'h0C, 8'h00};
        for (int i = 0; i < 6; i++) begin
            a_in_valid  = s_valid[i];
            a_in_data   = s_data[i];
            a_out_ready = s_ready[i];
            tick();
            checks++; if (a_occ !== e_occ[i]) begin errors++; $display("FAIL bp_occ[%0d]: got %0d want %0d", i, a_occ, e_occ[i]); end
            checks++; if (a_in_ready !== e_rdy[i]) begin errors++; $display("FAIL bp_in_ready[%0d]: got %b want %b", i, a_in_ready, e_rdy[i]); end
            if (e_occ[i] != 2'd0) begin
                checks++; if (a_out_data !== e_data[i]) begin errors++; $display("FAIL bp_data[%0d]: got %h want %h", i, a_out_data, e_data[i]); end
            end
        end
    endtask

    task automatic test_stall;
        a_out_ready = 1'b0;
        a_in_valid  = 1'b1;
        a_in_data   = 8'h55;
        tick();
        a_in_valid  = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (a_out_data !== 8'h55) begin errors++; $display("FAIL stall_data[%0d]: got %h want 55", i, a_out_data); end
            checks++; if (a_out_valid !== 1'b1) begin errors++; $display("FAIL stall_valid[%0d]: got %b want 1", i, a_out_valid); end
        end
        a_out_ready = 1'b1;
        tick();
        checks++; if (a_occ !== 2'd0) begin errors++; $display("FAIL stall_drain_occ: got %0d want 0", a_occ); end
    endtask

    task automatic test_flush;
        a_out_ready = 1'b0;
        a_in_valid  = 1'b1;
        a_in_data   = 8'h01;
        tick();
        a_in_data   = 8'h02;
        tick();
        checks++; if (a_occ !== 2'd2) begin errors++; $display("FAIL flush_pre_occ: got %0d want 2", a_occ); end
        a_flush     = 1'b1;
        a_out_ready = 1'b1;
        a_in_data   = 8'h03;
        tick();
        a_flush     = 1'b0;
        a_in_valid  = 1'b0;
        checks++; if (a_occ !== 2'd0) begin errors++; $display("FAIL flush_occ: got %0d want 0", a_occ); end
        checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b want 0", a_out_valid); end
        checks++; if (a_out_data !== A_RST) begin errors++; $display("FAIL flush_data: got %h want %h", a_out_data, A_RST); end
        checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL flush_in_ready: got %b want 1", a_in_ready); end
        tick();
        checks++; if (a_occ !== 2'd0) begin errors++; $display("FAIL flush_discard_occ: got %0d want 0", a_occ); end
        a_in_valid = 1'b1;
        a_in_data  = 8'h04;
        tick();
        a_in_valid = 1'b0;
        checks++; if (a_out_data !== 8'h04) begin errors++; $display("FAIL flush_next_data: got %h want 04", a_out_data); end
        checks++; if (a_occ !== 2'd1) begin errors++; $display("FAIL flush_next_occ: got %0d want 1", a_occ); end
        tick();
    endtask

    task automatic test_async_reset;
        a_out_ready = 1'b0;
        a_in_valid  = 1'b1;
        a_in_data   = 8'h08;
        tick();
        a_in_data   = 8'h09;
        tick();
        checks++; if (a_occ !== 2'd2) begin errors++; $display("FAIL areset_pre_occ: got %0d want 2", a_occ); end
        #3;
        reset = 1'b0;
        #1;
        checks++; if (a_occ !== 2'd0) begin errors++; $display("FAIL areset_occ: got %0d want 0", a_occ); end
        checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL areset_valid: got %b want 0", a_out_valid); end
        checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL areset_in_ready: got %b want 1", a_in_ready); end
        checks++; if (a_out_data !== A_RST) begin errors++; $display("FAIL areset_data: got %h want %h", a_out_data, A_RST); end
        #2;
        reset       = 1'b1;
        a_in_data   = 8'h07;
        a_out_ready = 1'b1;
        tick();
        a_in_valid  = 1'b0;
        checks++; if (a_out_data !== 8'h07) begin errors++; $display("FAIL areset_first_data: got %h want 07", a_out_data); end
        checks++; if (a_occ !== 2'd1) begin errors++; $display("FAIL areset_first_occ: got %0d want 1", a_occ); end
        tick();
        checks++; if (a_occ !== 2'd0) begin errors++; $display("FAIL areset_drain_occ: got %0d want 0", a_occ); end
    endtask

    task automatic test_scoreboard;
        logic [7:0]  qa [$];
        logic [63:0] qb [$];
        logic        ra, rb;
        logic        acc, con;
        reset = 1'b0;
        a_in_valid = 1'b0; a_out_ready = 1'b0; a_flush = 1'b0;
        b_in_valid = 1'b0; b_out_ready = 1'b0; b_flush = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        tick();
        for (int cyc = 0; cyc < 10000; cyc++) begin
            checks++; if (a_occ !== 2'(qa.size())) begin errors++; $display("FAIL sb8_occ @%0d: got %0d want %0d", cyc, a_occ, qa.size()); end
            checks++; if (a_in_ready !== (qa.size() < 2)) begin errors++; $display("FAIL sb8_in_ready @%0d: got %b want %b", cyc, a_in_ready, qa.size() < 2); end
            checks++; if (a_out_valid !== (qa.size() > 0)) begin errors++; $display("FAIL sb8_valid @%0d: got %b want %b", cyc, a_out_valid, qa.size() > 0); end
            if (qa.size() > 0) begin
                checks++; if (a_out_data !== qa[0]) begin errors++; $display("FAIL sb8_data @%0d: got %h want %h", cyc, a_out_data, qa[0]); end
            end
            checks++; if (b_occ !== 2'(qb.size())) begin errors++; $display("FAIL sb64_occ @%0d: got %0d want %0d", cyc, b_occ, qb.size()); end
            checks++; if (b_in_ready !== (qb.size() < 2)) begin errors++; $display("FAIL sb64_in_ready @%0d: got %b want %b", cyc, b_in_ready, qb.size() < 2); end
            checks++; if (b_out_valid !== (qb.size() > 0)) begin errors++; $display("FAIL sb64_valid @%0d: got %b want %b", cyc, b_out_valid, qb.size() > 0); end
            if (qb.size() > 0) begin
                checks++; if (b_out_data !== qb[0]) begin errors++; $display("FAIL sb64_data @%0d: got %h want %h", cyc, b_out_data, qb[0]); end
            end

            a_in_valid  = 1'($urandom_range(0, 1));
            a_out_ready = 1'($urandom_range(0, 1));
            a_in_data   = 8'($urandom());
            b_in_valid  = 1'($urandom_range(0, 1));
            b_out_ready = 1'($urandom_range(0, 1));
            b_in_data   = {$urandom(), $urandom()};

            acc = a_in_valid && (qa.size() < 2);
            con = a_out_ready && (qa.size() > 0);
            if (con) void'(qa.pop_front());
            if (acc) qa.push_back(a_in_data);
            acc = b_in_valid && (qb.size() < 2);
            con = b_out_ready && (qb.size() > 0);
            if (con) void'(qb.pop_front());
            if (acc) qb.push_back(b_in_data);

            // Wiggle out_ready mid-cycle; in_ready must not follow it.
            #1;
            ra = a_in_ready;
            rb = b_in_ready;
            a_out_ready = ~a_out_ready;
            b_out_ready = ~b_out_ready;
            #1;
            checks++; if (a_in_ready !== ra) begin errors++; $display("FAIL sb8_comb_ready @%0d: got %b want %b", cyc, a_in_ready, ra); end
            checks++; if (b_in_ready !== rb) begin errors++; $display("FAIL sb64_comb_ready @%0d: got %b want %b", cyc, b_in_ready, rb); end
            a_out_ready = ~a_out_ready;
            b_out_ready = ~b_out_ready;
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_stall();
        test_flush();
        test_async_reset();
        test_scoreboard();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errors);
        $finish;
    end

endmodule : tb_pipe_register
`default_nettype wire
